// File: rtl/ram_pattern_engine_if.sv
// Avalon-MM bus between the pattern engine and the single-port on-chip RAM (s1).
//   master : engine side, drives address/byteenable/chipselect/write/writedata/clken
//   slave  : RAM side, returns readdata one cycle after a read is presented
interface ram_pattern_engine_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] m_address;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_chipselect;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_clken;
   logic [DATA_W-1:0] m_readdata;

   modport master (
      output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      input  m_readdata
   );

   modport slave (
      input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      output m_readdata
   );
endinterface

// File: rtl/ram_pattern_engine.sv
// RAM pattern engine: fills a word range with seed+i and/or reads it back and
// compares, for power-on initialisation and built-in memory test.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start, abort         one-cycle request (IDLE only) / terminate operation
//   mode                 0=fill, 1=fill+verify, 2=verify, 3=fill
//   base_addr,word_count,seed  operation range and pattern seed
//   bus                  Avalon-MM master to the RAM s1 port
//   busy, done, pass, range_err, err_count, first_err_addr  status/results
module ram_pattern_engine #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 5120,
   parameter int unsigned ERR_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           mode,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      word_count,
   input  logic [DATA_W-1:0]    seed,
   ram_pattern_engine_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 range_err,
   output logic [ERR_W-1:0]     err_count,
   output logic [ADDR_W-1:0]    first_err_addr
);
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic                wtr_q, wtr_d;          // read back after writing (mode 1)
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [ADDR_W:0]     idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   exp_data_q, exp_data_d;
   logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [ADDR_W-1:0]   ferr_q, ferr_d;
   logic                pass_q, pass_d;
   logic                rerr_q, rerr_d;
   logic                busy_q, done_q;
   logic                last_c;
   logic                wr_c, rd_c;

   assign last_c = (idx_q + CNT_ONE) == count_q;

   // Bus outputs are gated by abort so the RAM sees no access in the abort cycle.
   assign wr_c = (state_q == S_WRITE) && !abort;
   assign rd_c = (state_q == S_READ)  && !abort;

   assign bus.m_byteenable = '1;
   assign bus.m_clken      = 1'b1;
   assign bus.m_chipselect = wr_c || rd_c;
   assign bus.m_write      = wr_c;
   assign bus.m_address    = (wr_c || rd_c) ? addr_q : '0;
   assign bus.m_writedata  = wr_c ? data_q : '0;

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign range_err      = rerr_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;

   // Next-state, sequencing and compare logic.
   always_comb begin
      state_d    = state_q;
      wtr_d      = wtr_q;
      base_d     = base_q;
      count_d    = count_q;
      seed_d     = seed_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_valid_d = 1'b0;
      exp_data_d = data_q;
      exp_addr_d = addr_q;
      err_d      = err_q;
      ferr_d     = ferr_q;
      pass_d     = pass_q;
      rerr_d     = rerr_q;

      // Compare the word read in the previous cycle; runs even in an abort cycle.
      if (rd_valid_q && (bus.m_readdata != exp_data_q)) begin
         if (err_q == '0) ferr_d = exp_addr_q;
         if (err_q != '1) err_d = err_q + ERR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               wtr_d   = (mode == 2'd1);
               base_d  = base_addr;
               count_d = word_count;
               seed_d  = seed;
               idx_d   = '0;
               addr_d  = base_addr;
               data_d  = seed;
               err_d   = '0;
               ferr_d  = '0;
               pass_d  = 1'b0;
               rerr_d  = 1'b0;
               if (word_count == '0) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               // count is bounded first so the sum cannot wrap in ADDR_W+1 bits
               end else if ((word_count > DEPTH_L) ||
                            (({1'b0, base_addr} + word_count) > DEPTH_L)) begin
                  state_d = S_DONE;
                  rerr_d  = 1'b1;
               end else if (mode == 2'd2) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_d = S_DONE;
               pass_d  = 1'b0;
            end else begin
               idx_d  = idx_q + CNT_ONE;
               addr_d = addr_q + ADDR_W'(1);
               data_d = data_q + DATA_W'(1);
               if (last_c) begin
                  if (wtr_q) begin
                     state_d = S_READ;
                     idx_d   = '0;
                     addr_d  = base_q;
                     data_d  = seed_q;
                  end else begin
                     state_d = S_DONE;
                     pass_d  = (err_d == '0);
                  end
               end
            end
         end
         S_READ: begin
            if (abort) begin
               state_d = S_DONE;
               pass_d  = 1'b0;
            end else begin
               rd_valid_d = 1'b1;
               idx_d      = idx_q + CNT_ONE;
               addr_d     = addr_q + ADDR_W'(1);
               data_d     = data_q + DATA_W'(1);
               if (last_c) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            pass_d  = !abort && (err_d == '0);
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wtr_q      <= 1'b0;
         base_q     <= '0;
         count_q    <= '0;
         seed_q     <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
         exp_data_q <= '0;
         exp_addr_q <= '0;
         err_q      <= '0;
         ferr_q     <= '0;
         pass_q     <= 1'b0;
         rerr_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wtr_q      <= wtr_d;
         base_q     <= base_d;
         count_q    <= count_d;
         seed_q     <= seed_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_valid_q <= rd_valid_d;
         exp_data_q <= exp_data_d;
         exp_addr_q <= exp_addr_d;
         err_q      <= err_d;
         ferr_q     <= ferr_d;
         pass_q     <= pass_d;
         rerr_q     <= rerr_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
      end
   end
endmodule

// File: tb/tb_ram_pattern_engine.sv
// Directed self-checking bench for ram_pattern_engine. dut1 talks to a RAM
// model with one-cycle read latency; dut2 (ERR_W=2) reads constant zero.
module tb_ram_pattern_engine;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 5120;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n, start, start2, abort;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   word_count;
   logic [DATA_W-1:0] seed;

   logic              busy, done, pass, range_err;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;
   logic              busy2, done2, pass2, range_err2;
   logic [1:0]        err_count2;
   logic [ADDR_W-1:0] first_err_addr2;

   ram_pattern_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
   ram_pattern_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

   ram_pattern_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
      .base_addr(base_addr), .word_count(word_count), .seed(seed), .bus(bus1),
      .busy(busy), .done(done), .pass(pass), .range_err(range_err),
      .err_count(err_count), .first_err_addr(first_err_addr)
   );

   ram_pattern_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort), .mode(mode),
      .base_addr(base_addr), .word_count(word_count), .seed(seed), .bus(bus2),
      .busy(busy2), .done(done2), .pass(pass2), .range_err(range_err2),
      .err_count(err_count2), .first_err_addr(first_err_addr2)
   );

   assign bus2.m_readdata = '0;

   // RAM model with a bench-side preload port.
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   logic              tb_we;
   logic [ADDR_W-1:0] tb_addr;
   logic [DATA_W-1:0] tb_wdata;
   always @(posedge clk) begin
      if (tb_we) ram[tb_addr] <= tb_wdata;
      else if (bus1.m_chipselect) begin
         if (bus1.m_write) ram[bus1.m_address] <= bus1.m_writedata;
         else bus1.m_readdata <= ram[bus1.m_address];
      end
   end

   int cs_cycles = 0;
   always @(negedge clk) if (bus1.m_chipselect === 1'b1) cs_cycles <= cs_cycles + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int cur      = 0;

   task automatic step();
      @(posedge clk); #1;
      cur++;
   endtask

   // Start pulse in cycle 0; returns at the beginning of cycle 1.
   task automatic go(input int which, input logic [1:0] md, input logic [ADDR_W-1:0] b,
                     input logic [ADDR_W:0] c, input logic [DATA_W-1:0] s, input logic ab);
      @(posedge clk); #1;
      mode = md; base_addr = b; word_count = c; seed = s; abort = ab;
      if (which == 0) start = 1'b1; else start2 = 1'b1;
      cur = 0;
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0; abort = 1'b0;
      cur = 1;
   endtask

   // Returns the cycle index of the done pulse, or -1 when the budget runs out.
   task automatic wait_done(input int which, input int limit, output int lat);
      bit seen = 1'b0;
      lat = -1;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk);
         if (((which == 0) ? done : done2) === 1'b1) begin
            seen = 1'b1;
            lat  = cur;
         end else begin
            step();
         end
      end
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      tb_we = 1'b1; tb_addr = a; tb_wdata = d;
      step();
      tb_we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, pass, range_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_status: got busy/done/pass/rerr=%b, expected 0000", {busy, done, pass, range_err});
      end
      n_checks++;
      if ({err_count, first_err_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_results: got err=%h first=%h, expected 0 0", err_count, first_err_addr);
      end
      n_checks++;
      if ({bus1.m_chipselect, bus1.m_write, bus1.m_clken, bus1.m_byteenable, bus1.m_address, bus1.m_writedata}
          !== {1'b0, 1'b0, 1'b1, 4'hF, 13'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_bus: got cs=%b wr=%b clken=%b be=%h addr=%h wd=%h, expected 0 0 1 f 0 0",
                  bus1.m_chipselect, bus1.m_write, bus1.m_clken, bus1.m_byteenable, bus1.m_address, bus1.m_writedata);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_fill();
      int lat;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      go(0, 2'd0, 13'h100, 14'd4, 32'hA000_0000, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         ea = 13'h100 + 13'(k - 1);
         ed = 32'hA000_0000 + 32'(k - 1);
         @(negedge clk);
         n_checks++;
         if ({bus1.m_chipselect, bus1.m_write, bus1.m_address, bus1.m_writedata} !== {1'b1, 1'b1, ea, ed}) begin
            n_fail++;
            $display("FAIL fill_word%0d: got cs=%b wr=%b addr=%h wd=%h, expected cs=1 wr=1 addr=%h wd=%h",
                     k, bus1.m_chipselect, bus1.m_write, bus1.m_address, bus1.m_writedata, ea, ed);
         end
         step();
      end
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 5 || pass !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_done: got cycle=%0d pass=%b busy=%b, expected cycle=5 pass=1 busy=1", lat, pass, busy);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({done, busy, pass} !== 3'b001) begin
         n_fail++;
         $display("FAIL fill_after: got done/busy/pass=%b, expected 001", {done, busy, pass});
      end
   endtask

   task automatic test_fill_verify();
      int lat;
      go(0, 2'd1, 13'h0, 14'd8, 32'h1234_5678, 1'b0);
      wait_done(0, 40, lat);
      n_checks++;
      if (lat != 18 || pass !== 1'b1 || err_count !== 16'd0 || range_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_verify: got cycle=%0d pass=%b err=%0d rerr=%b, expected cycle=18 pass=1 err=0 rerr=0",
                  lat, pass, err_count, range_err);
      end
      n_checks++;
      if (ram[7] !== 32'h1234_567F) begin
         n_fail++;
         $display("FAIL fill_verify_ram: got ram[7]=%h, expected 1234567f", ram[7]);
      end
   endtask

   task automatic test_verify_corrupt();
      int lat;
      poke(13'h10, 32'h0);
      poke(13'h11, 32'h1);
      poke(13'h12, 32'hFFFF_FFFF);
      poke(13'h13, 32'h3);
      go(0, 2'd2, 13'h10, 14'd4, 32'h0, 1'b0);
      wait_done(0, 20, lat);
      n_checks++;
      if (lat != 6 || err_count !== 16'd1 || first_err_addr !== 13'h12 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL verify_corrupt: got cycle=%0d err=%0d first=%h pass=%b, expected cycle=6 err=1 first=12 pass=0",
                  lat, err_count, first_err_addr, pass);
      end
   endtask

   task automatic test_boundary();
      int lat;
      int cs0;
      go(0, 2'd0, 13'd5118, 14'd2, 32'h7, 1'b0);
      step();
      @(negedge clk);
      n_checks++;
      if ({bus1.m_chipselect, bus1.m_address} !== {1'b1, 13'd5119}) begin
         n_fail++;
         $display("FAIL boundary_last_addr: got cs=%b addr=%0d, expected cs=1 addr=5119", bus1.m_chipselect, bus1.m_address);
      end
      step();
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 3 || pass !== 1'b1 || range_err !== 1'b0) begin
         n_fail++;
         $display("FAIL boundary_fit: got cycle=%0d pass=%b rerr=%b, expected cycle=3 pass=1 rerr=0", lat, pass, range_err);
      end
      step();
      cs0 = cs_cycles;
      go(0, 2'd0, 13'd5119, 14'd2, 32'h0, 1'b0);
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 1 || range_err !== 1'b1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL boundary_over: got cycle=%0d rerr=%b pass=%b, expected cycle=1 rerr=1 pass=0", lat, range_err, pass);
      end
      step();
      n_checks++;
      if (cs_cycles != cs0) begin
         n_fail++;
         $display("FAIL boundary_over_cs: got %0d chipselect cycles, expected 0", cs_cycles - cs0);
      end
      go(0, 2'd2, 13'd0, 14'd5121, 32'h0, 1'b0);
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 1 || range_err !== 1'b1) begin
         n_fail++;
         $display("FAIL boundary_count: got cycle=%0d rerr=%b, expected cycle=1 rerr=1", lat, range_err);
      end
      go(0, 2'd1, 13'd40, 14'd0, 32'h0, 1'b0);
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 1 || pass !== 1'b1 || range_err !== 1'b0) begin
         n_fail++;
         $display("FAIL boundary_zero: got cycle=%0d pass=%b rerr=%b, expected cycle=1 pass=1 rerr=0", lat, pass, range_err);
      end
   endtask

   task automatic test_start_abort_same();
      int lat;
      go(0, 2'd3, 13'h20, 14'd2, 32'h5, 1'b1);
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 3 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL start_abort_same: got cycle=%0d pass=%b, expected cycle=3 pass=1", lat, pass);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      go(0, 2'd0, 13'h200, 14'd3, 32'h55, 1'b0);
      step();
      start = 1'b1; base_addr = 13'h300; word_count = 14'd10; seed = 32'h0;
      @(negedge clk);
      n_checks++;
      if ({bus1.m_address, bus1.m_writedata} !== {13'h201, 32'h56}) begin
         n_fail++;
         $display("FAIL busy_start_c2: got addr=%h wd=%h, expected addr=201 wd=56", bus1.m_address, bus1.m_writedata);
      end
      step();
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus1.m_address, bus1.m_writedata} !== {13'h202, 32'h57}) begin
         n_fail++;
         $display("FAIL busy_start_c3: got addr=%h wd=%h, expected addr=202 wd=57", bus1.m_address, bus1.m_writedata);
      end
      step();
      wait_done(0, 10, lat);
      n_checks++;
      if (lat != 4 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start_done: got cycle=%0d pass=%b, expected cycle=4 pass=1", lat, pass);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({busy, bus1.m_chipselect} !== 2'b00) begin
         n_fail++;
         $display("FAIL busy_start_idle: got busy=%b cs=%b, expected 0 0", busy, bus1.m_chipselect);
      end
   endtask

   task automatic test_abort();
      go(0, 2'd1, 13'h0, 14'd100, 32'h0, 1'b0);
      while (cur < 49) step();
      @(negedge clk);
      n_checks++;
      if (bus1.m_chipselect !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: got cs=%b at cycle 49, expected 1", bus1.m_chipselect);
      end
      step();
      abort = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus1.m_chipselect, bus1.m_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_bus: got cs=%b wr=%b at cycle 50, expected 0 0", bus1.m_chipselect, bus1.m_write);
      end
      step();
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done, pass} !== 2'b10) begin
         n_fail++;
         $display("FAIL abort_done: got done=%b pass=%b at cycle 51, expected 1 0", done, pass);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_idle: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_reset_midop();
      go(0, 2'd1, 13'h0, 14'd100, 32'h0, 1'b0);
      while (cur < 50) step();
      reset_n = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({done, busy, pass, bus1.m_chipselect, bus1.m_write, bus1.m_clken, bus1.m_byteenable, bus1.m_address, err_count}
             !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 13'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_midop%0d: got done=%b busy=%b pass=%b cs=%b wr=%b clken=%b be=%h addr=%h err=%h, expected 0 0 0 0 0 1 f 0 0",
                     k, done, busy, pass, bus1.m_chipselect, bus1.m_write, bus1.m_clken, bus1.m_byteenable,
                     bus1.m_address, err_count);
         end
         step();
      end
      reset_n = 1'b1;
   endtask

   task automatic test_saturation();
      int lat;
      go(1, 2'd2, 13'h40, 14'd6, 32'h1, 1'b0);
      wait_done(1, 20, lat);
      n_checks++;
      if (lat != 8 || err_count2 !== 2'd3 || first_err_addr2 !== 13'h40 || pass2 !== 1'b0) begin
         n_fail++;
         $display("FAIL saturation: got cycle=%0d err=%0d first=%h pass=%b, expected cycle=8 err=3 first=40 pass=0",
                  lat, err_count2, first_err_addr2, pass2);
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0;
      mode = 2'd0; base_addr = '0; word_count = '0; seed = '0;
      tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
      test_reset();
      test_fill();
      test_fill_verify();
      test_verify_corrupt();
      test_boundary();
      test_start_abort_same();
      test_back_to_back();
      test_abort();
      test_reset_midop();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_pattern_engine.md
Name: ram_pattern_engine

Overview:
- Avalon-MM master sitting directly upstream of the on-chip 32-bit single-port RAM; drives its s1 port (address, byteenable, chipselect, write, writedata, clken) and consumes readdata.
- Fills a word range with a deterministic pattern and/or reads the range back and compares.
- Used for power-on RAM initialisation and built-in memory test; controlled by a start/done handshake from the system controller.

Parameters:
- ADDR_W, 13, word-address width of the RAM port.
- DATA_W, 32, data width; byteenable is DATA_W/8 bits.
- DEPTH, 5120, number of valid words; range-check limit.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminate current operation
- mode  in  2  0=fill, 1=fill+verify, 2=verify only, 3=reserved (treated as 0)
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  number of words
- seed  in  DATA_W  pattern seed
- m_address  out  ADDR_W  RAM address
- m_byteenable  out  DATA_W/8  RAM byte enables
- m_chipselect  out  1  RAM chipselect
- m_write  out  1  RAM write strobe
- m_writedata  out  DATA_W  RAM write data
- m_clken  out  1  RAM clock enable
- m_readdata  in  DATA_W  RAM read data; valid exactly 1 cycle after the address is presented with chipselect=1, write=0
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result: no mismatches, no range error, not aborted
- range_err  out  1  request rejected
- err_count  out  ERR_W  mismatch count; saturates at all-ones
- first_err_addr  out  ADDR_W  address of the first mismatch

Behaviour:
- Pattern: word i (0-based) = seed + i, modulo 2^DATA_W; address = base_addr + i.
- Bus outputs:
  - m_byteenable is constant all-ones.
  - m_clken is constant 1.
  - m_chipselect=1 only in WRITE/READ.
  - m_write=1 only in WRITE.
  - Bus outputs are 0 in every other state.
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; all outputs 0, except m_clken=1 and m_byteenable=all-ones.
  - Results are cleared.
  - Reset mid-operation abandons the operation with no done pulse.
- States and transitions:
  - IDLE: on start, latch mode/base/count/seed; clear err_count, first_err_addr, pass, range_err.
    - If word_count==0: go to DONE with pass=1.
    - Else if base_addr+word_count > DEPTH: go to DONE with range_err=1, pass=0; no bus cycle issued.
    - Else go to WRITE (mode 0/1/3) or READ (mode 2).
  - WRITE: one write per cycle for word_count cycles. After the last word, go to READ (mode 1) or DONE.
  - READ: one read per cycle for word_count cycles; a valid flag is pipelined 1 cycle alongside the expected data and address. After the last issue, go to DRAIN.
  - DRAIN: one cycle to compare the final read word; then go to DONE.
  - DONE: done=1 for exactly one cycle; pass = (err_count==0 && !range_err && !aborted); return to IDLE.
- Compare: in the cycle after each read issue, if m_readdata != expected:
  - err_count increments, saturating.
  - first_err_addr is captured only on the first mismatch.
- Latency from start (cycle 0) to the done pulse, N = word_count:
  - mode 0: N+1.
  - mode 2: N+2.
  - mode 1: 2N+2.
  - zero/range-error cases: 1.
- busy is 1 from the cycle after start through the DONE cycle inclusive.
- start while busy is ignored.
- abort in any non-IDLE state: the next state is DONE, bus outputs drop immediately that cycle, pass=0.
  - A compare pending from the previous cycle is still evaluated.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- Results hold their values until the next accepted start.
- Address arithmetic uses ADDR_W+1 bits for the range check; the last valid address is DEPTH-1.

Test Plan:
- Fill: mode=0, base=0x100, count=4, seed=0xA0000000 -> writes 0xA0000000..0xA0000003 to 0x100..0x103 on cycles 1..4; done at cycle 5; pass=1.
- Fill+verify with a RAM model: mode=1, base=0, count=8, seed=0x12345678 -> done at cycle 18; pass=1; err_count=0.
- Corrupted word: preload the RAM, mode=2, base=0x10, count=4, seed=0, with the word at 0x12 corrupted to 0xFFFFFFFF -> err_count=1, first_err_addr=0x12, pass=0, done at cycle 6.
- Range/boundary:
  - base=5118, count=2 -> pass=1, last address 5119.
  - base=5119, count=2 -> range_err=1, no chipselect, done at cycle 1.
  - count=0 -> done at cycle 1, pass=1.
- Abort and reset:
  - mode=1, count=100, abort at cycle 50 -> chipselect=0 at cycle 50, done at cycle 51, pass=0.
  - Repeat with reset_n=0 at cycle 50 -> no done pulse; all outputs at reset values.
- Saturation/ignore: ERR_W=2 with every word mismatched over count=6 -> err_count=3; a start issued while busy does not alter the latched base/count.
